// File: rtl/video_pkg.sv
// Shared types and Avalon-MM widths for the video block writer.
package video_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    BURST = 2'd2
  } state_e;

  localparam int AVM_AW  = 30;
  localparam int AVM_DW  = 32;
  localparam int AVM_BCW = 8;

  // Byte address of a word inside the ring, computed in 32 bits and
  // truncated to the width of the Avalon address port.
  function automatic logic [AVM_AW-1:0] block_addr(
    input logic [31:0] base,
    input logic [31:0] blk,
    input logic [31:0] word,
    input logic [31:0] block_words
  );
    return AVM_AW'(base + ((blk * block_words + word) << 2));
  endfunction

endpackage

// File: rtl/video_block_writer_sync_fifo.sv
// Single-clock first-word-fall-through FIFO: the head word is always visible
// on rdata while the FIFO is not empty; pop advances to the next word.
module sync_fifo #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [AW:0]   count_next;

  // Requests against a full/empty FIFO are ignored rather than corrupting it.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Occupancy after this cycle; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage array; no reset needed since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == DEPTH);
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/video_block_writer.sv
// Streaming-to-Avalon-MM burst writer: buffers the pixel stream in a FIFO and
// writes it as fixed-length bursts into a ring of blocks in SDRAM, publishing
// the index of each completed block.
//
// Handshakes: a stream word transfers on a cycle with st_valid && st_ready;
// an Avalon beat transfers on a cycle with avm_write && !avm_waitrequest, and
// address/burstcount/writedata are held stable while waitrequest is high.
module video_block_writer
  import video_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int          BLOCK_WORDS = 4096,
  parameter int          NUM_BLOCKS  = 8,
  parameter int          BURST_LEN   = 16,
  parameter int          FIFO_AW     = 6
) (
  input  logic               avalon_clk,
  input  logic               avalon_reset_n,
  input  logic               enable,
  input  logic [31:0]        st_data,
  input  logic               st_valid,
  output logic               st_ready,
  output logic [AVM_AW-1:0]  avm_address,
  output logic [AVM_BCW-1:0] avm_burstcount,
  output logic               avm_write,
  output logic [AVM_DW-1:0]  avm_writedata,
  output logic [3:0]         avm_byteenable,
  input  logic               avm_waitrequest,
  output logic [31:0]        blk_number,
  output logic               blk_done,
  output logic               busy,
  output logic [15:0]        drop_cnt,
  output state_e             fsm_state
);

  localparam logic [7:0]         LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [FIFO_AW:0]   BURST_CNT = (FIFO_AW+1)'(BURST_LEN);
  localparam logic [31:0]        BLK_LAST  = 32'(NUM_BLOCKS - 1);
  localparam logic [31:0]        BW32      = 32'(BLOCK_WORDS);
  localparam logic [31:0]        BL32      = 32'(BURST_LEN);

  state_e           state;
  logic [31:0]      blk;
  logic [31:0]      word;
  logic [7:0]       beat_cnt;

  logic [31:0]      fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FIFO_AW:0] fifo_count;
  logic             fifo_push;
  logic             fifo_pop;
  logic             beat_done;
  logic             burst_ready;
  logic [31:0]      word_next;

  assign st_ready       = !fifo_full && enable;
  assign fifo_push      = st_valid && st_ready;
  assign beat_done      = (state == BURST) && avm_write && !avm_waitrequest;
  // ARM loads the first word; every beat except the last loads the next one.
  assign fifo_pop       = !fifo_empty &&
                          ((state == ARM) || (beat_done && beat_cnt != LAST_BEAT));
  assign burst_ready    = enable && (fifo_count >= BURST_CNT);
  assign word_next      = word + BL32;
  assign avm_byteenable = 4'hF;
  assign busy           = (state != IDLE);
  assign fsm_state      = state;

  sync_fifo #(
    .DW (32),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (avalon_clk),
    .rst_n (avalon_reset_n),
    .push  (fifo_push),
    .wdata (st_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Burst sequencer: only whole bursts are issued, and a started burst always
  // completes regardless of enable.
  always_ff @(posedge avalon_clk or negedge avalon_reset_n) begin
    if (!avalon_reset_n) begin
      state          <= IDLE;
      avm_address    <= '0;
      avm_burstcount <= '0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      blk            <= '0;
      word           <= '0;
      beat_cnt       <= '0;
      blk_number     <= BLK_LAST;
      blk_done       <= 1'b0;
    end else begin
      blk_done <= 1'b0;
      case (state)
        IDLE: begin
          if (burst_ready) state <= ARM;
        end
        ARM: begin
          avm_address    <= block_addr(BASE_ADDR, blk, word, BW32);
          avm_burstcount <= AVM_BCW'(BURST_LEN);
          avm_writedata  <= fifo_rdata;
          avm_write      <= 1'b1;
          beat_cnt       <= '0;
          state          <= BURST;
        end
        BURST: begin
          if (beat_done) begin
            if (beat_cnt == LAST_BEAT) begin
              avm_write <= 1'b0;
              if (word_next == BW32) begin
                word       <= '0;
                blk        <= (blk == BLK_LAST) ? '0 : blk + 32'd1;
                blk_number <= blk;
                blk_done   <= 1'b1;
                state      <= IDLE;
              end else begin
                word  <= word_next;
                state <= burst_ready ? ARM : IDLE;
              end
            end else begin
              beat_cnt      <= beat_cnt + 8'd1;
              avm_writedata <= fifo_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of words offered while the FIFO could not take them.
  always_ff @(posedge avalon_clk or negedge avalon_reset_n) begin
    if (!avalon_reset_n) begin
      drop_cnt <= '0;
    end else if (st_valid && fifo_full && enable && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_video_block_writer.sv
// Directed bench for video_block_writer with a small ring (4 blocks of 32
// words, bursts of 16). A monitor checks every Avalon beat against a model of
// the ring pointer and an expected-data queue.
module tb_video_block_writer;
  import video_pkg::*;

  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam int BW = 32;
  localparam int NB = 4;
  localparam int BL = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic               enable;
  logic [31:0]        st_data;
  logic               st_valid;
  logic               st_ready;
  logic [AVM_AW-1:0]  avm_address;
  logic [AVM_BCW-1:0] avm_burstcount;
  logic               avm_write;
  logic [AVM_DW-1:0]  avm_writedata;
  logic [3:0]         avm_byteenable;
  logic               avm_waitrequest;
  logic [31:0]        blk_number;
  logic               blk_done;
  logic               busy;
  logic [15:0]        drop_cnt;
  state_e             fsm_state;

  logic wr_hold;
  logic rand_mode;
  logic rand_wr;
  assign avm_waitrequest = rand_mode ? rand_wr : wr_hold;

  video_block_writer #(
    .BASE_ADDR   (BASE),
    .BLOCK_WORDS (BW),
    .NUM_BLOCKS  (NB),
    .BURST_LEN   (BL),
    .FIFO_AW     (6)
  ) dut (
    .avalon_clk      (clk),
    .avalon_reset_n  (rst_n),
    .enable          (enable),
    .st_data         (st_data),
    .st_valid        (st_valid),
    .st_ready        (st_ready),
    .avm_address     (avm_address),
    .avm_burstcount  (avm_burstcount),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .blk_number      (blk_number),
    .blk_done        (blk_done),
    .busy            (busy),
    .drop_cnt        (drop_cnt),
    .fsm_state       (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] blk_q[$];
  logic [31:0] first_addr_q[$];
  int done_cnt = 0;
  int m_blk = 0;
  int m_word = 0;
  int m_beat = 0;
  logic [31:0] last_burst_addr = '0;
  logic prev_hold = 1'b0;
  logic [AVM_AW-1:0]  prev_addr;
  logic [AVM_BCW-1:0] prev_bc;
  logic [31:0]        prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_addr(input int b, input int w);
    logic [31:0] full;
    full = BASE + 32'((b * BW + w) * 4);
    return {2'b00, full[29:0]};
  endfunction

  // 50% random waitrequest, changed away from the active edge.
  always @(negedge clk) rand_wr = 1'($urandom_range(0, 1));

  // Beat monitor: samples between the falling edge and the next rising edge.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (blk_done) begin
        done_cnt++;
        blk_q.push_back(blk_number);
      end
      if (avm_write) begin
        if (prev_hold) begin
          chk("hold_addr", 32'(avm_address), 32'(prev_addr));
          chk("hold_burstcount", 32'(avm_burstcount), 32'(prev_bc));
          chk("hold_data", avm_writedata, prev_data);
        end
        if (!avm_waitrequest) begin
          prev_hold = 1'b0;
          if (m_beat == 0) begin
            chk("burst_addr", 32'(avm_address), model_addr(m_blk, m_word));
            chk("burst_count", 32'(avm_burstcount), 32'(BL));
            last_burst_addr = 32'(avm_address);
            if (m_word == 0) first_addr_q.push_back(32'(avm_address));
          end
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", avm_writedata, 32'hDEAD_BEEF);
          end else begin
            chk("beat_data", avm_writedata, exp_q.pop_front());
          end
          m_beat++;
          if (m_beat == BL) begin
            m_beat = 0;
            m_word += BL;
            if (m_word == BW) begin
              m_word = 0;
              m_blk = (m_blk + 1) % NB;
            end
          end
        end else begin
          prev_hold = 1'b1;
          prev_addr = avm_address;
          prev_bc   = avm_burstcount;
          prev_data = avm_writedata;
        end
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic send_word(input logic [31:0] d);
    int guard = 0;
    st_data  = d;
    st_valid = 1'b1;
    #1;
    while (!st_ready && guard < 1000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("send_accept", 32'(st_ready), 32'd1);
    if (st_ready) exp_q.push_back(d);
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int guard = 0;
    while (done_cnt < target && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk(tag, 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_beat(input int n, input string tag);
    int guard = 0;
    while (m_beat < n && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk(tag, 32'(m_beat >= n), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int acc;
    logic [31:0] exp_blk [5];
    exp_blk[0] = 32'd0; exp_blk[1] = 32'd1; exp_blk[2] = 32'd2;
    exp_blk[3] = 32'd3; exp_blk[4] = 32'd0;

    rst_n = 1'b0; enable = 1'b1; st_valid = 1'b0; st_data = '0;
    wr_hold = 1'b0; rand_mode = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_write", 32'(avm_write), 32'd0);
    chk("rst_addr", 32'(avm_address), 32'd0);
    chk("rst_burstcount", 32'(avm_burstcount), 32'd0);
    chk("rst_writedata", avm_writedata, 32'd0);
    chk("rst_byteenable", 32'(avm_byteenable), 32'hF);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_blk_number", blk_number, 32'(NB - 1));
    chk("rst_blk_done", 32'(blk_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic block with latency check: first write two cycles after 16 words.
    for (int i = 0; i < 16; i++) send_word(32'(i));
    #1;
    chk("lat0_write", 32'(avm_write), 32'd0);
    chk("lat0_busy", 32'(busy), 32'd0);
    @(negedge clk); #1;
    chk("lat1_write", 32'(avm_write), 32'd0);
    chk("lat1_state", 32'(fsm_state), 32'(ARM));
    @(negedge clk); #1;
    chk("lat2_write", 32'(avm_write), 32'd1);
    chk("lat2_addr", 32'(avm_address), model_addr(0, 0));
    chk("lat2_data", avm_writedata, 32'd0);
    for (int i = 16; i < 32; i++) send_word(32'(i));
    wait_done(1, "basic_done");
    chk("basic_blk_number", blk_number, 32'd0);
    chk("basic_drained", 32'(exp_q.size()), 32'd0);

    // Random 50% waitrequest.
    rand_mode = 1'b1;
    for (int i = 0; i < 32; i++) send_word(32'h100 + 32'(i));
    wait_done(2, "rand_done");
    rand_mode = 1'b0;
    chk("rand_blk_number", blk_number, 32'd1);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    // Drop enable at beat 5; burst completes, then resumes at word 16.
    wr_hold = 1'b1;
    for (int i = 0; i < 32; i++) send_word(32'h200 + 32'(i));
    chk("stall_write_held", 32'(avm_write), 32'd1);
    wr_hold = 1'b0;
    wait_beat(5, "en_beat5");
    enable = 1'b0;
    wait_idle("en_idle");
    chk("en_word", 32'(m_word), 32'd16);
    chk("en_state", 32'(fsm_state), 32'(IDLE));
    repeat (10) @(negedge clk);
    chk("en_still_idle", 32'(busy), 32'd0);
    chk("en_no_write", 32'(avm_write), 32'd0);
    enable = 1'b1;
    wait_done(3, "resume_done");
    chk("resume_addr", last_burst_addr, model_addr(2, 16));
    chk("resume_blk_number", blk_number, 32'd2);

    // Ring wrap: blocks 3 and 0.
    for (int i = 0; i < 64; i++) send_word(32'h300 + 32'(i));
    wait_done(5, "wrap_done");
    chk("wrap_blk_count", 32'(blk_q.size()), 32'd5);
    if (blk_q.size() >= 5)
      for (int i = 0; i < 5; i++) chk("wrap_blk_seq", blk_q[i], exp_blk[i]);
    chk("wrap_first_count", 32'(first_addr_q.size()), 32'd5);
    if (first_addr_q.size() >= 5) begin
      chk("wrap_blk3_addr", first_addr_q[3], 32'h2000_0180);
      chk("wrap_blk0_addr", first_addr_q[4], {2'b00, BASE[29:0]});
    end

    // Overflow: waitrequest held, stream offered for 200 cycles.
    wr_hold = 1'b1;
    acc = 0;
    for (int i = 0; i < 200; i++) begin
      st_valid = 1'b1;
      st_data  = 32'h1000 + 32'(acc);
      #1;
      if (st_ready) begin
        exp_q.push_back(st_data);
        acc++;
      end
      @(negedge clk);
    end
    #1;
    chk("ovf_st_ready", 32'(st_ready), 32'd0);
    st_valid = 1'b0;
    chk("ovf_accepted", 32'(acc), 32'd65);
    chk("ovf_drop_cnt", 32'(drop_cnt), 32'd135);
    wr_hold = 1'b0;
    wait_done(7, "ovf_done");
    chk("ovf_blk_number", blk_number, 32'd2);
    chk("ovf_drop_kept", 32'(drop_cnt), 32'd135);
    chk("ovf_leftover", 32'(exp_q.size()), 32'd1);

    // Reset at beat 8 of a burst.
    wr_hold = 1'b1;
    for (int i = 0; i < 32; i++) send_word(32'h2000 + 32'(i));
    wr_hold = 1'b0;
    wait_beat(8, "rst_beat8");
    rst_n = 1'b0;
    #1;
    chk("mrst_write", 32'(avm_write), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_blk_number", blk_number, 32'(NB - 1));
    chk("mrst_st_ready", 32'(st_ready), 32'd1);
    chk("mrst_drop_cnt", 32'(drop_cnt), 32'd0);
    exp_q.delete();
    blk_q.delete();
    first_addr_q.delete();
    done_cnt = 0;
    m_blk = 0; m_word = 0; m_beat = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) send_word(32'h3000 + 32'(i));
    wait_done(1, "post_rst_done");
    chk("post_rst_blk_number", blk_number, 32'd0);
    chk("post_rst_first_count", 32'(first_addr_q.size()), 32'd1);
    if (first_addr_q.size() >= 1)
      chk("post_rst_addr", first_addr_q[0], {2'b00, BASE[29:0]});
    chk("post_rst_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
